// File: rtl/expr_eval_sched_if.sv
// Bundle between the scheduler and its environment: requesters, shared evaluator, response consumer.
// slave = scheduler side, master = requesters/evaluator/consumer side.
interface expr_eval_sched_if #(
  parameter int NREQ = 4,
  parameter int OPW  = 60,
  parameter int RESW = 90
) ();
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_operands;
  logic [OPW-1:0]      eval_a;
  logic [RESW-1:0]     eval_y;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [RESW-1:0]     rsp_data;
  logic                busy;
  logic [RESW-1:0]     rsp_csum;

  modport slave (
    input  req_valid, req_operands, eval_y, rsp_ready,
    output req_ready, eval_a, rsp_valid, rsp_id, rsp_data, busy, rsp_csum
  );

  modport master (
    output req_valid, req_operands, eval_y, rsp_ready,
    input  req_ready, eval_a, rsp_valid, rsp_id, rsp_data, busy, rsp_csum
  );
endinterface

// File: rtl/expr_eval_sched.sv
// Round-robin scheduler sharing one combinational expression evaluator; result back after EVAL_LAT+1 cycles.
// Response held until rsp_ready; no accepts while busy. Define EXPR_EVAL_SCHED_CSUM_EN to build the response XOR checksum.
module expr_eval_sched #(
  parameter int NREQ     = 4,
  parameter int OPW      = 60,
  parameter int RESW     = 90,
  parameter int EVAL_LAT = 2
) (
  input logic              clk,
  input logic              reset,
  expr_eval_sched_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [OPW-1:0]  eval_a_q, eval_a_d;
  logic [RESW-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_id;
  logic [NREQ-1:0] grant_oh;
  logic            accept;
  logic            rsp_hs;

  // Search starts one past the last winner so every requester is reached within NREQ-1 grants.
  always_comb begin : arb
    int             idx;
    logic [IDW-1:0] idx_v;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    idx_v       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(last_q) + 1 + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_v = IDW'(idx);
      if (!grant_found && bus.req_valid[idx_v]) begin
        grant_found = 1'b1;
        grant_id    = idx_v;
      end
    end
  end

  assign grant_oh      = grant_found ? (NREQ'(1) << grant_id) : '0;
  assign bus.req_ready = (state_q == IDLE && !reset) ? grant_oh : '0;
  assign accept        = |(bus.req_ready & bus.req_valid);
  assign rsp_hs        = (state_q == RESP) && bus.rsp_ready;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    rsp_id_d    = rsp_id_q;
    cnt_d       = cnt_q;
    eval_a_d    = eval_a_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          eval_a_d = bus.req_operands[int'(grant_id)*OPW +: OPW];
          rsp_id_d = grant_id;
          last_d   = grant_id;
          cnt_d    = 4'(EVAL_LAT);
          state_d  = EVAL;
        end
      end
      EVAL: begin
        if (cnt_q == 4'd1) begin
          rsp_data_d  = bus.eval_y;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      rsp_id_q    <= '0;
      cnt_q       <= '0;
      eval_a_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rsp_id_q    <= rsp_id_d;
      cnt_q       <= cnt_d;
      eval_a_q    <= eval_a_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.eval_a    = eval_a_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (state_q != IDLE);

`ifdef EXPR_EVAL_SCHED_CSUM_EN
  logic [RESW-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (rsp_hs) csum_d = csum_q ^ rsp_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign bus.rsp_csum = csum_q;
`else
  assign bus.rsp_csum = '0;
`endif
endmodule

// File: tb/tb_expr_eval_sched.sv
// Directed bench for expr_eval_sched with a stub evaluator y = ~{30'b0, a}, overridable for checksum vectors.
module tb_expr_eval_sched;
  localparam logic [59:0] OP0 = 60'h123456789ABCDEF;
  localparam logic [59:0] OP1 = 60'hFEDCBA987654321;
  localparam logic [59:0] OP2 = 60'h0F0F0F0F0F0F0F0;
  localparam logic [59:0] OP3 = 60'h555555555555555;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic        stub_force = 1'b0;
  logic [89:0] stub_val = '0;
  int vectors = 0;
  int miscompares = 0;
  logic [59:0] ops [4];
  logic [89:0] exp_csum;

  expr_eval_sched_if #(.NREQ(4), .OPW(60), .RESW(90)) bus ();

  expr_eval_sched #(.NREQ(4), .OPW(60), .RESW(90), .EVAL_LAT(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.eval_y = stub_force ? stub_val : ~{30'b0, bus.eval_a};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [89:0] obs, input logic [89:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    ops[0] = OP0; ops[1] = OP1; ops[2] = OP2; ops[3] = OP3;
    bus.req_valid    = '0;
    bus.req_operands = {OP3, OP2, OP1, OP0};
    bus.rsp_ready    = 1'b0;

    // Reset state
    cyc();
    do_reset();
    check("rst_rsp_valid", 90'(bus.rsp_valid), 90'd0);
    check("rst_eval_a", 90'(bus.eval_a), 90'd0);
    check("rst_rsp_id", 90'(bus.rsp_id), 90'd0);
    check("rst_rsp_data", bus.rsp_data, 90'd0);
    check("rst_busy", 90'(bus.busy), 90'd0);
    check("rst_csum", bus.rsp_csum, 90'd0);
    check("rst_req_ready", 90'(bus.req_ready), 90'd0);

    // Single request from requester 1, accepted at T, response at T+3
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0010;
    #1;
    check("single_ready_T", 90'(bus.req_ready), 90'h2);
    cyc();
    bus.req_valid = 4'b0000;
    check("single_busy_T1", 90'(bus.busy), 90'd1);
    check("single_eval_a_T1", 90'(bus.eval_a), 90'(OP1));
    check("single_valid_T1", 90'(bus.rsp_valid), 90'd0);
    cyc();
    check("single_valid_T2", 90'(bus.rsp_valid), 90'd0);
    cyc();
    check("single_valid_T3", 90'(bus.rsp_valid), 90'd1);
    check("single_id_T3", 90'(bus.rsp_id), 90'd1);
    check("single_data_T3", bus.rsp_data, ~{30'b0, OP1});
    cyc();
    check("single_valid_T4", 90'(bus.rsp_valid), 90'd0);
    check("single_busy_T4", 90'(bus.busy), 90'd0);
    check("single_eval_a_hold", 90'(bus.eval_a), 90'(OP1));

    // All four requesting continuously: grants rotate 0,1,2,3,0,1 every 4 cycles
    bus.req_valid = 4'b1111;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      check("rr_ready", 90'(bus.req_ready), 90'(4'b0001 << (k % 4)));
      cyc();
      check("rr_ready_eval", 90'(bus.req_ready), 90'd0);
      check("rr_eval_a", 90'(bus.eval_a), 90'(ops[k % 4]));
      cyc();
      cyc();
      check("rr_rsp_valid", 90'(bus.rsp_valid), 90'd1);
      check("rr_rsp_id", 90'(bus.rsp_id), 90'(k % 4));
      cyc();
    end

    // Backpressure: response held five cycles with rsp_ready low
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    do_reset();
    check("bp_ready_T", 90'(bus.req_ready), 90'h1);
    cyc();
    bus.req_valid = 4'b1111;
    cyc();
    cyc();
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 90'(bus.rsp_valid), 90'd1);
      check("bp_rsp_id", 90'(bus.rsp_id), 90'd0);
      check("bp_rsp_data", bus.rsp_data, ~{30'b0, OP0});
      check("bp_req_ready", 90'(bus.req_ready), 90'd0);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_still_valid", 90'(bus.rsp_valid), 90'd1);
    cyc();
    check("bp_released", 90'(bus.rsp_valid), 90'd0);
    check("bp_idle", 90'(bus.busy), 90'd0);
    check("bp_next_grant", 90'(bus.req_ready), 90'h2);
    bus.req_valid = 4'b0000;
    #1;

    // Reset during EVAL discards the in-flight request
    bus.req_valid = 4'b0100;
    do_reset();
    check("mid_ready_T", 90'(bus.req_ready), 90'h4);
    cyc();
    bus.req_valid = 4'b0000;
    check("mid_busy_T1", 90'(bus.busy), 90'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid_rsp_valid", 90'(bus.rsp_valid), 90'd0);
    check("mid_eval_a", 90'(bus.eval_a), 90'd0);
    check("mid_busy", 90'(bus.busy), 90'd0);
    bus.req_valid = 4'b0101;
    #1;
    check("mid_req0_wins", 90'(bus.req_ready), 90'h1);
    bus.req_valid = 4'b0000;
    #1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("mid_no_rsp", 90'(bus.rsp_valid), 90'd0);
    end

    // Requester 2 drops while 0 is in flight; next grant goes to 3
    bus.req_valid = 4'b1101;
    do_reset();
    check("drop_ready_T", 90'(bus.req_ready), 90'h1);
    cyc();
    bus.req_valid = 4'b1000;
    cyc();
    cyc();
    check("drop_rsp_id0", 90'(bus.rsp_id), 90'd0);
    cyc();
    check("drop_next_grant", 90'(bus.req_ready), 90'h8);
    cyc();
    bus.req_valid = 4'b0000;
    cyc();
    cyc();
    check("drop_rsp_valid3", 90'(bus.rsp_valid), 90'd1);
    check("drop_rsp_id3", 90'(bus.rsp_id), 90'd3);
    cyc();

    // Checksum over responses 5 then 3
`ifdef EXPR_EVAL_SCHED_CSUM_EN
    exp_csum = 90'h6;
`else
    exp_csum = 90'h0;
`endif
    do_reset();
    stub_force = 1'b1;
    stub_val = 90'h5;
    bus.req_valid = 4'b0001;
    cyc();
    bus.req_valid = 4'b0000;
    cyc();
    cyc();
    check("csum_rsp_data5", bus.rsp_data, 90'h5);
    cyc();
    stub_val = 90'h3;
    bus.req_valid = 4'b0010;
    cyc();
    bus.req_valid = 4'b0000;
    cyc();
    cyc();
    check("csum_rsp_data3", bus.rsp_data, 90'h3);
    cyc();
    check("csum_final", bus.rsp_csum, exp_csum);
    stub_force = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/expr_eval_sched.md
# expr_eval_sched

Round-robin scheduler that shares one combinational expression evaluator (12 packed operands in, 90-bit result out) among NREQ requesters. It accepts a request over a valid/ready handshake and drives the operands onto the evaluator through a held register. It waits a configurable settle time, captures the 90-bit result, and returns it tagged with the requester id. It sits between the regression stimulus sources and the shared expression unit.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8
- OPW, 60: packed operand width; {a0,a1,a2,a3,a4,a5,b0,b1,b2,b3,b4,b5} = 4+5+6+4+5+6 twice
- RESW, 90: evaluator result width
- EVAL_LAT, 2: settle cycles the evaluator is given, 1..15

Ports:
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  one-hot accept, combinational from state/arbitration
- req_operands  in  NREQ*OPW  requester i occupies bits [i*OPW +: OPW]
- eval_a  out  OPW  registered operands to shared evaluator
- eval_y  in  RESW  evaluator result (combinational of eval_a)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  $clog2(NREQ)  requester index of the response
- rsp_data  out  RESW  captured eval_y
- busy  out  1  state != IDLE
- rsp_csum  out  RESW  running XOR of delivered responses (see Configuration)

## Operation
- States: IDLE, EVAL, RESP; encoding is free.
- IDLE: the winner is the first asserted req_valid searching from (last+1) mod NREQ upward, with wrap. req_ready = one-hot winner; all zero if no valid.
- Accept (IDLE and req_valid[g] and req_ready[g]): eval_a <= operands of g; rsp_id <= g; last <= g; cnt <= EVAL_LAT; go to EVAL.
- EVAL: cnt decrements each cycle. When cnt == 1: rsp_data <= eval_y, rsp_valid <= 1, go to RESP.
- RESP: rsp_valid, rsp_id and rsp_data are held stable until rsp_ready. On handshake: rsp_valid <= 0, go to IDLE.
- req_ready is 0 in EVAL and RESP. Requesters may drop req_valid at any time. A request counts only on handshake.
- eval_a holds its value after capture until the next accept.
- Simultaneous requests: exactly one is granted per IDLE cycle, fair rotation. No requester waits more than NREQ-1 grants.
- Single requester: it is granted repeatedly, with no bubble beyond the state sequence.
- Reset values: req_ready 0, eval_a 0, rsp_valid 0, rsp_id 0, rsp_data 0, busy 0, rsp_csum 0, last NREQ-1 (so req 0 wins first), state IDLE.
- Reset mid-operation (EVAL or RESP): the in-flight request is discarded, no response is issued, and all of the above values load next edge.

## Timing
- The accept cycle is T. eval_a is valid from T+1.
- EVAL occupies T+1 .. T+EVAL_LAT.
- rsp_valid rises at T+EVAL_LAT+1.
- With rsp_ready held high: RESP lasts 1 cycle, IDLE lasts 1 cycle. Peak throughput is 1 request per EVAL_LAT+2 cycles.
- Backpressure: each cycle rsp_ready is low extends RESP by one cycle. No request is accepted meanwhile.
- EVAL_LAT=1: EVAL lasts exactly one cycle, and capture happens on that cycle's edge.

## Configuration
- EXPR_EVAL_SCHED_CSUM_EN defined: rsp_csum <= rsp_csum ^ rsp_data on every response handshake. It clears on reset.
- Not defined: rsp_csum is tied to 0 and no checksum register is built. All other behaviour is identical.

## Test plan
- Single request, EVAL_LAT=2: req_valid[1], eval stub y=~{30'b0,a}. Required: accept at T, rsp_valid at T+3, rsp_id=1, rsp_data equals stub output for those operands.
- All 4 valid continuously, rsp_ready=1, from reset. Required: grants 0,1,2,3,0,…; a new accept every 4 cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. Required: rsp_data/rsp_id stable, req_ready all 0, then response delivered and IDLE re-entered.
- Reset asserted in cycle T+1 of EVAL. Required: next cycle rsp_valid=0, eval_a=0, busy=0; the dropped request yields no response, and req 0 wins the next arbitration.
- Requester 2 drops req_valid while 0 is in flight, only 3 remains. Required: the next grant goes to 3, and 2 never appears in rsp_id.
- With EXPR_EVAL_SCHED_CSUM_EN: responses 90'h5 then 90'h3. Required: rsp_csum = 90'h6. Without the macro, rsp_csum stays 0.
